// File: rtl/audiodac_fifo_mc_if.sv
// Bus bundle for the multi-channel audio DAC FIFO: writer handshake,
// modulator read strobe, status/level outputs and control inputs.
//
// Write handshake (4-phase req/ack): the writer raises fifo_rdy_i with
// fifo_data_i stable, the FIFO stores exactly one frame and raises
// fifo_ack_o, the writer drops fifo_rdy_i, and the FIFO then drops
// fifo_ack_o. While the FIFO is full the request simply waits unacknowledged.
interface audiodac_fifo_mc_if #(
  parameter int AUDIO_WIDTH = 16,
  parameter int NUM_CH      = 2,
  parameter int FIFO_SIZE   = 6
);
  logic [NUM_CH*AUDIO_WIDTH-1:0] fifo_data_i;
  logic                          fifo_rdy_i;
  logic                          fifo_ack_o;
  logic                          fifo_full_o;
  logic                          fifo_empty_o;
  logic                          fifo_afull_o;
  logic                          fifo_aempty_o;
  logic [FIFO_SIZE:0]            fifo_level_o;
  logic [NUM_CH*AUDIO_WIDTH-1:0] audio_data_o;
  logic                          audio_rd_i;
  logic [7:0]                    underrun_cnt_o;
  logic                          underrun_clr_i;
  logic                          fifo_flush_i;
  logic                          tst_fifo_loop_i;

  // FIFO side
  modport slave (
    input  fifo_data_i, fifo_rdy_i, audio_rd_i, underrun_clr_i,
           fifo_flush_i, tst_fifo_loop_i,
    output fifo_ack_o, fifo_full_o, fifo_empty_o, fifo_afull_o,
           fifo_aempty_o, fifo_level_o, audio_data_o, underrun_cnt_o
  );

  // Writer / modulator / control side
  modport master (
    output fifo_data_i, fifo_rdy_i, audio_rd_i, underrun_clr_i,
           fifo_flush_i, tst_fifo_loop_i,
    input  fifo_ack_o, fifo_full_o, fifo_empty_o, fifo_afull_o,
           fifo_aempty_o, fifo_level_o, audio_data_o, underrun_cnt_o
  );
endinterface

// File: rtl/audiodac_fifo_mc.sv
// Multi-channel audio DAC FIFO. Frames arrive over a 4-phase req/ack
// handshake (optionally from another clock domain) and are consumed by the
// delta-sigma modulator read strobe. All 2^FIFO_SIZE slots are usable: the
// pointers carry one extra bit to tell full from empty. On underrun the last
// frame read is held on the output and an 8-bit saturating counter ticks.
module audiodac_fifo_mc #(
  parameter int AUDIO_WIDTH = 16,
  parameter int NUM_CH      = 2,
  parameter int FIFO_SIZE   = 6,
  parameter int FIFO_ASYNC  = 1,
  parameter int AFULL_LVL   = 48,
  parameter int AEMPTY_LVL  = 16
) (
  input logic                clk_i,
  input logic                rst_n_i,
  audiodac_fifo_mc_if.slave  bus
);
  localparam int DW    = NUM_CH * AUDIO_WIDTH;
  localparam int DEPTH = 1 << FIFO_SIZE;
  localparam int PW    = FIFO_SIZE + 1;

  localparam logic [AUDIO_WIDTH-1:0] MID      = {1'b1, {(AUDIO_WIDTH-1){1'b0}}};
  localparam logic [PW-1:0]          DEPTH_L  = PW'(DEPTH);
  localparam logic [PW-1:0]          AFULL_L  = PW'(AFULL_LVL);
  localparam logic [PW-1:0]          AEMPTY_L = PW'(AEMPTY_LVL);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] level;
  logic          ack;
  logic          full;
  logic          empty;
  logic          rdy_s;
  logic [DW-1:0] data_s;
  logic          wr_en;
  logic          rd_en;
  logic          underrun_inc;
  logic [DW-1:0] hold;
  logic [DW-1:0] rd_data;
  logic [7:0]    underrun_cnt;

  // Request/data capture: two-flop synchroniser for an asynchronous writer,
  // straight through otherwise. Data travels in the same stage as rdy.
  generate
    if (FIFO_ASYNC != 0) begin : g_sync
      logic          rdy_d1;
      logic          rdy_d2;
      logic [DW-1:0] data_d1;
      logic [DW-1:0] data_d2;

      // Resynchronise request and frame into clk_i
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          rdy_d1  <= 1'b0;
          rdy_d2  <= 1'b0;
          data_d1 <= '0;
          data_d2 <= '0;
        end else begin
          rdy_d1  <= bus.fifo_rdy_i;
          rdy_d2  <= rdy_d1;
          data_d1 <= bus.fifo_data_i;
          data_d2 <= data_d1;
        end
      end

      assign rdy_s  = rdy_d2;
      assign data_s = data_d2;
    end else begin : g_direct
      assign rdy_s  = bus.fifo_rdy_i;
      assign data_s = bus.fifo_data_i;
    end
  endgenerate

  // Level and flags, all derived from the pre-edge pointer difference
  always_comb begin
    level   = wr_ptr - rd_ptr;
    full    = (level == DEPTH_L);
    empty   = (level == '0);
    rd_data = mem[rd_ptr[FIFO_SIZE-1:0]];
    // One frame per request pulse: ack must fall before the next accept
    wr_en   = rdy_s && !ack && !full;
    // Flush and loop mode take the read pointer away from normal reads
    rd_en        = bus.audio_rd_i && !empty && !bus.fifo_flush_i && !bus.tst_fifo_loop_i;
    underrun_inc = bus.audio_rd_i && empty && !bus.fifo_flush_i && !bus.tst_fifo_loop_i;
  end

  // Write pointer and acknowledge
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      ack    <= 1'b0;
    end else if (!rdy_s) begin
      ack <= 1'b0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + PW'(1);
      ack    <= 1'b1;
    end
  end

  // Frame storage, intentionally not reset
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_ptr[FIFO_SIZE-1:0]] <= data_s;
    end
  end

  // Read pointer and last-frame hold register; flush wins over reads
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr <= '0;
      hold   <= {NUM_CH{MID}};
    end else if (bus.fifo_flush_i) begin
      rd_ptr <= wr_ptr;
    end else if (bus.tst_fifo_loop_i) begin
      if (bus.audio_rd_i) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end else if (rd_en) begin
      rd_ptr <= rd_ptr + PW'(1);
      hold   <= rd_data;
    end
  end

  // Saturating underrun counter; clear beats a same-cycle increment
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      underrun_cnt <= 8'd0;
    end else if (bus.underrun_clr_i) begin
      underrun_cnt <= 8'd0;
    end else if (underrun_inc && (underrun_cnt != 8'hFF)) begin
      underrun_cnt <= underrun_cnt + 8'd1;
    end
  end

  assign bus.fifo_ack_o     = ack;
  assign bus.fifo_full_o    = full;
  assign bus.fifo_empty_o   = empty;
  assign bus.fifo_afull_o   = (level >= AFULL_L);
  assign bus.fifo_aempty_o  = (level <= AEMPTY_L);
  assign bus.fifo_level_o   = level;
  assign bus.audio_data_o   = (empty && !bus.tst_fifo_loop_i) ? hold : rd_data;
  assign bus.underrun_cnt_o = underrun_cnt;
endmodule
